// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for NUM_DIG common-anode seven-segment digits
// Ports:
//    clk_i    system clock, rising edge
//    rst_i    synchronous active-high reset
//    data_i   value to display, nibble k = digit k
//    load_i   load request level, held with data_i until ack_o
//    lz_en_i  leading-zero suppression enable, sampled at capture
//    ack_o    one-cycle pulse after data_i is captured into the shadow
//    dig_o    nibble for the shared hex decoder
//    blank_o  high forces the segments off
//    an_o     active-low anode selects, at most one low
module seg7_scan_ctrl #(
   parameter int NUM_DIG = 4,
   parameter int CLK_DIV = 50000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [4*NUM_DIG-1:0] data_i,
   input  logic                 load_i,
   input  logic                 lz_en_i,
   output logic                 ack_o,
   output logic [3:0]           dig_o,
   output logic                 blank_o,
   output logic [NUM_DIG-1:0]   an_o
);
   localparam int PW = $clog2(CLK_DIV);
   localparam int IW = $clog2(NUM_DIG);
   logic [PW-1:0]        pcnt_q, pcnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 first_q, first_d, pend_q, pend_d, tick_q, tick_d;
   logic [4*NUM_DIG-1:0] shadow_q, shadow_d;
   logic [NUM_DIG-1:0]   mask_q, mask_d, lz_mask, an_q, an_d;
   logic [3:0]           dig_q, dig_d;
   logic                 blank_q, blank_d, ack_q, ack_d;
   logic                 tick, last, capture;
   // digit k blanks when it and every more significant nibble are zero; digit 0 always shows
   always_comb begin
      logic z;
      z = 1'b1;
      lz_mask = '0;
      for (int k = NUM_DIG - 1; k > 0; k--) begin
         z = z & (data_i[4*k +: 4] == 4'h0);
         lz_mask[k] = lz_en_i & z;
      end
   end
   always_comb begin
      tick     = pcnt_q == PW'(CLK_DIV - 1);
      last     = idx_q == IW'(NUM_DIG - 1);
      capture  = tick & last & (pend_q | load_i);
      pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
      // the first tick after reset opens slot 0 instead of advancing past it
      idx_d    = (!tick || first_q) ? idx_q : (last ? '0 : idx_q + 1'b1);
      first_d  = first_q & ~tick;
      pend_d   = ~capture & (pend_q | load_i);
      shadow_d = capture ? data_i : shadow_q;
      mask_d   = capture ? lz_mask : mask_q;
      tick_d   = tick;
      // one all-ones dead cycle at each slot change before the new anode drops
      an_d     = tick ? '1 : (tick_q ? ~(NUM_DIG'(1) << idx_q) : an_q);
      dig_d    = tick ? shadow_d[{idx_d, 2'b00} +: 4] : dig_q;
      blank_d  = tick ? mask_d[idx_d] : blank_q;
      ack_d    = capture;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pcnt_q   <= '0;
         idx_q    <= '0;
         first_q  <= 1'b1;
         pend_q   <= 1'b0;
         tick_q   <= 1'b0;
         shadow_q <= '0;
         mask_q   <= '0;
         an_q     <= '1;
         dig_q    <= 4'h0;
         blank_q  <= 1'b1;
         ack_q    <= 1'b0;
      end else begin
         pcnt_q   <= pcnt_d;
         idx_q    <= idx_d;
         first_q  <= first_d;
         pend_q   <= pend_d;
         tick_q   <= tick_d;
         shadow_q <= shadow_d;
         mask_q   <= mask_d;
         an_q     <= an_d;
         dig_q    <= dig_d;
         blank_q  <= blank_d;
         ack_q    <= ack_d;
      end
   end
   assign ack_o   = ack_q;
   assign dig_o   = dig_q;
   assign blank_o = blank_q;
   assign an_o    = an_q;
endmodule
